// File: rtl/c64_debug_pkg.sv
// Shared definitions for the C64 debug DMA path: FSM encoding, default timing
// constants and the debug command opcodes used by the host-side decoder.
package c64_debug_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HALT,
      ST_SLOT,
      ST_ACCESS,
      ST_DONE,
      ST_DROP
   } dma_state_t;

   localparam int DEFAULT_HALT_CYCLES = 3;
   localparam int DEFAULT_TIMEOUT     = 1000000;

   typedef enum logic [7:0] {
      CMD_READ  = 8'd1,
      CMD_WRITE = 8'd2,
      CMD_PS2   = 8'd3,
      CMD_RESET = 8'd4
   } debug_cmd_t;

endpackage

// File: rtl/c64_debug_dma.sv
// Debug DMA: halts the 6510, waits out its unstoppable write cycles, then
// performs one bus access in a VIC-free phi2-high phase and acks the initiator.
module c64_debug_dma
   import c64_debug_pkg::*;
#(
   parameter int HALT_CYCLES = DEFAULT_HALT_CYCLES,
   parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        debug_request,
   input  logic [15:0] debug_addr,
   input  logic        debug_we,
   input  logic [7:0]  debug_data_o,
   output logic [7:0]  debug_data_i,
   output logic        debug_ack,
   input  logic        phi2_rise,
   input  logic        phi2_fall,
   input  logic        ba,
   output logic        cpu_halt,
   output logic        bus_oe,
   output logic [15:0] bus_addr,
   output logic        bus_we,
   output logic [7:0]  bus_do,
   input  logic [7:0]  bus_di
);

   localparam int HW = (HALT_CYCLES > 1) ? $clog2(HALT_CYCLES) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   dma_state_t       state, state_n;
   logic [HW-1:0]    halt_cnt, halt_cnt_n;
   logic [TW-1:0]    to_cnt, to_cnt_n;
   logic [15:0]      addr_q, addr_n;
   logic             we_q, we_n;
   logic [7:0]       data_q, data_n;
   logic [7:0]       data_i_n;
   logic             ack_n, halt_n, oe_n, bus_we_n;
   logic [15:0]      bus_addr_n;
   logic [7:0]       bus_do_n;
   logic             timed_out;

   assign timed_out = (to_cnt == TW'(TIMEOUT));

   // NOTE: every signal gets its hold value first, so no path through the case leaves one unassigned and infers a latch.
   always_comb begin
      state_n    = state;
      halt_cnt_n = halt_cnt;
      to_cnt_n   = to_cnt;
      addr_n     = addr_q;
      we_n       = we_q;
      data_n     = data_q;
      data_i_n   = debug_data_i;
      ack_n      = 1'b0;
      halt_n     = cpu_halt;
      oe_n       = bus_oe;
      bus_we_n   = bus_we;
      bus_addr_n = bus_addr;
      bus_do_n   = bus_do;

      if (state != ST_IDLE && state != ST_DROP && !timed_out)
         to_cnt_n = to_cnt + 1'b1;

      case (state)
         ST_IDLE: begin
            if (debug_request) begin
               addr_n     = debug_addr;
               we_n       = debug_we;
               data_n     = debug_data_o;
               halt_n     = 1'b1;
               halt_cnt_n = '0;
               to_cnt_n   = '0;
               state_n    = ST_HALT;
            end
         end
         ST_HALT: begin
            if (timed_out) begin
               state_n = ST_DONE;
            end else if (phi2_fall) begin
               if (halt_cnt == HW'(HALT_CYCLES - 1)) state_n = ST_SLOT;
               else                                  halt_cnt_n = halt_cnt + 1'b1;
            end
         end
         ST_SLOT: begin
            // A rise coinciding with a fall is a broken strobe pair; never start on it.
            if (timed_out) begin
               state_n = ST_DONE;
            end else if (phi2_rise && !phi2_fall && ba) begin
               oe_n       = 1'b1;
               bus_addr_n = addr_q;
               bus_we_n   = we_q;
               bus_do_n   = data_q;
               state_n    = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (timed_out) begin
               state_n = ST_DONE;
            end else if (phi2_fall) begin
               if (!bus_we) data_i_n = bus_di;
               oe_n     = 1'b0;
               bus_we_n = 1'b0;
               ack_n    = 1'b1;
               halt_n   = 1'b0;
               state_n  = ST_DONE;
            end
         end
         ST_DONE: state_n = ST_DROP;
         ST_DROP: if (!debug_request) state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase

      // Abort path: the initiator still gets its ack, with an all-ones read result.
      if (timed_out && (state == ST_HALT || state == ST_SLOT || state == ST_ACCESS)) begin
         data_i_n = 8'hFF;
         oe_n     = 1'b0;
         bus_we_n = 1'b0;
         ack_n    = 1'b1;
         halt_n   = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         halt_cnt     <= '0;
         to_cnt       <= '0;
         addr_q       <= '0;
         we_q         <= 1'b0;
         data_q       <= '0;
         debug_data_i <= '0;
         debug_ack    <= 1'b0;
         cpu_halt     <= 1'b0;
         bus_oe       <= 1'b0;
         bus_we       <= 1'b0;
         bus_addr     <= '0;
         bus_do       <= '0;
      end else begin
         state        <= state_n;
         halt_cnt     <= halt_cnt_n;
         to_cnt       <= to_cnt_n;
         addr_q       <= addr_n;
         we_q         <= we_n;
         data_q       <= data_n;
         debug_data_i <= data_i_n;
         debug_ack    <= ack_n;
         cpu_halt     <= halt_n;
         bus_oe       <= oe_n;
         bus_we       <= bus_we_n;
         bus_addr     <= bus_addr_n;
         bus_do       <= bus_do_n;
      end
   end

endmodule

// File: tb/tb_c64_debug_dma.sv
// Directed bench for c64_debug_dma: read, write, ba stall, strobe clash,
// initiator abort, held request, timeout (second instance) and async reset.
module tb_c64_debug_dma;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        debug_request = 1'b0, req_t = 1'b0;
   logic [15:0] debug_addr = '0;
   logic        debug_we = 1'b0;
   logic [7:0]  debug_data_o = '0;
   logic        phi2_rise = 1'b0, phi2_fall = 1'b0, ba = 1'b1;
   logic [7:0]  bus_di = '0;

   logic [7:0]  debug_data_i, data_t;
   logic        debug_ack, ack_t, cpu_halt, halt_t, bus_oe, oe_t, bus_we, we_t;
   logic [15:0] bus_addr, addr_t;
   logic [7:0]  bus_do, do_t;

   int vectors = 0, miscompares = 0;
   int ack_a = 0, ack_tc = 0, oe_cycles = 0, oe_viol = 0;

   always #5 clk = ~clk;

   c64_debug_dma dut (
      .clk(clk), .reset(reset), .debug_request(debug_request), .debug_addr(debug_addr),
      .debug_we(debug_we), .debug_data_o(debug_data_o), .debug_data_i(debug_data_i),
      .debug_ack(debug_ack), .phi2_rise(phi2_rise), .phi2_fall(phi2_fall), .ba(ba),
      .cpu_halt(cpu_halt), .bus_oe(bus_oe), .bus_addr(bus_addr), .bus_we(bus_we),
      .bus_do(bus_do), .bus_di(bus_di)
   );

   c64_debug_dma #(.TIMEOUT(100)) dut_t (
      .clk(clk), .reset(reset), .debug_request(req_t), .debug_addr(debug_addr),
      .debug_we(debug_we), .debug_data_o(debug_data_o), .debug_data_i(data_t),
      .debug_ack(ack_t), .phi2_rise(1'b0), .phi2_fall(1'b0), .ba(ba),
      .cpu_halt(halt_t), .bus_oe(oe_t), .bus_addr(addr_t), .bus_we(we_t),
      .bus_do(do_t), .bus_di(bus_di)
   );

   always @(negedge clk) begin
      if (debug_ack) ack_a++;
      if (ack_t) ack_tc++;
      if (bus_oe) oe_cycles++;
      if ((bus_oe && !cpu_halt) || (oe_t && !halt_t)) oe_viol++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_rise();
      phi2_rise = 1'b1; step(); phi2_rise = 1'b0;
   endtask

   task automatic pulse_fall();
      phi2_fall = 1'b1; step(); phi2_fall = 1'b0;
   endtask

   task automatic phi2_cyc(input logic b);
      ba = b; pulse_rise(); step(); pulse_fall(); step();
   endtask

   initial begin
      int oe0, held, cnt, acks0;

      repeat (3) step();
      check("rst_halt", cpu_halt, 0);
      check("rst_oe", bus_oe, 0);
      check("rst_we", bus_we, 0);
      check("rst_addr", bus_addr, 0);
      check("rst_do", bus_do, 0);
      check("rst_data", debug_data_i, 0);
      check("rst_ack", debug_ack, 0);
      reset = 1'b0;
      step();

      // Read D020
      debug_addr = 16'hD020; debug_we = 1'b0; bus_di = 8'h0E; ba = 1'b1;
      debug_request = 1'b1;
      step();
      check("rd_halt", cpu_halt, 1);
      oe0 = oe_cycles;
      repeat (3) phi2_cyc(1'b1);
      check("rd_no_oe_in_halt", oe_cycles - oe0, 0);
      check("rd_no_early_ack", ack_a, 0);
      pulse_rise();
      check("rd_oe", bus_oe, 1);
      check("rd_addr", bus_addr, 16'hD020);
      check("rd_we", bus_we, 0);
      check("rd_halt_hold", cpu_halt, 1);
      step(); step();
      pulse_fall();
      check("rd_ack_latency", debug_ack, 1);
      check("rd_oe_released", bus_oe, 0);
      check("rd_data", debug_data_i, 8'h0E);
      check("rd_halt_released", cpu_halt, 0);
      check("rd_oe_span", oe_cycles - oe0, 3);
      step();
      check("rd_ack_single", debug_ack, 0);
      check("rd_ack_count", ack_a, 1);
      debug_request = 1'b0;
      step();

      // Write 0400 <= 41, then hold the request
      debug_addr = 16'h0400; debug_we = 1'b1; debug_data_o = 8'h41; bus_di = 8'h99;
      debug_request = 1'b1;
      step();
      repeat (3) phi2_cyc(1'b1);
      pulse_rise();
      check("wr_oe", bus_oe, 1);
      check("wr_we", bus_we, 1);
      check("wr_addr", bus_addr, 16'h0400);
      check("wr_do", bus_do, 8'h41);
      step();
      pulse_fall();
      check("wr_ack", debug_ack, 1);
      check("wr_we_released", bus_we, 0);
      check("wr_data_kept", debug_data_i, 8'h0E);
      held = 0;
      repeat (50) begin
         step();
         if (cpu_halt) held++;
      end
      check("held_no_rehalt", held, 0);
      check("held_ack_count", ack_a, 2);
      debug_request = 1'b0;
      step();

      // Read 1234 with ba low, initiator abort, strobe clash in SLOT and ACCESS
      debug_addr = 16'h1234; debug_we = 1'b0; bus_di = 8'h55;
      debug_request = 1'b1;
      step();
      check("ba_rehalt", cpu_halt, 1);
      repeat (3) phi2_cyc(1'b1);
      debug_request = 1'b0;
      oe0 = oe_cycles;
      repeat (40) phi2_cyc(1'b0);
      check("ba_low_no_oe", oe_cycles - oe0, 0);
      check("ba_low_halt", cpu_halt, 1);
      ba = 1'b1; phi2_rise = 1'b1; phi2_fall = 1'b1;
      step();
      phi2_rise = 1'b0; phi2_fall = 1'b0;
      check("clash_slot_ignored", bus_oe, 0);
      pulse_rise();
      check("ba_first_oe", bus_oe, 1);
      check("ba_addr", bus_addr, 16'h1234);
      step();
      phi2_rise = 1'b1; phi2_fall = 1'b1;
      step();
      phi2_rise = 1'b0; phi2_fall = 1'b0;
      check("clash_access_ack", debug_ack, 1);
      check("abort_data", debug_data_i, 8'h55);
      step(); step();
      check("abort_ack_count", ack_a, 3);
      check("abort_halt_off", cpu_halt, 0);

      // Timeout on the TIMEOUT=100 instance, no strobes at all
      req_t = 1'b1;
      cnt = 0;
      for (int i = 0; i < 300; i++) begin
         step();
         cnt++;
         if (ack_t) break;
      end
      check("to_latency", cnt, 102);
      check("to_data", data_t, 8'hFF);
      check("to_halt_off", halt_t, 0);
      check("to_oe_off", oe_t, 0);
      req_t = 1'b0;
      step(); step();
      check("to_ack_count", ack_tc, 1);

      // Reset pulsed while the bus is owned
      debug_addr = 16'h2000; debug_we = 1'b0;
      debug_request = 1'b1;
      step();
      repeat (3) phi2_cyc(1'b1);
      pulse_rise();
      check("rst_mid_oe", bus_oe, 1);
      acks0 = ack_a;
      reset = 1'b1;
      #1;
      check("rst_mid_halt", cpu_halt, 0);
      check("rst_mid_oe_off", bus_oe, 0);
      step(); step();
      reset = 1'b0; debug_request = 1'b0;
      step(); step();
      check("rst_mid_no_ack", ack_a, acks0);
      check("rst_mid_data", debug_data_i, 0);
      check("oe_implies_halt", oe_viol, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
